// File: rtl/conv_weight_fetch.sv
// ---------------------------------------------------------------------------
// conv_weight_fetch
// Upstream sequencer for the conv weight ROM. A start request for kernel k
// walks the TAPS = KSIZE*KSIZE consecutive ROM addresses starting at k*TAPS.
// It absorbs the fixed ROM read latency and packs the returned words into one
// flat weight vector. The vector is then offered to the MAC array with a
// valid/ready handshake.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   start        fetch request for kernel_idx (pulse or level)
//   kernel_idx   kernel to fetch, sampled together with start
//   busy         high whenever the sequencer is not idle
//   err          one-cycle pulse for a start with kernel_idx >= NUM_KERNELS
//   rom_addr     registered ROM address
//   rom_clk_en   ROM clock enable, high while addresses or data are in flight
//   rom_rd_data  ROM read data, valid ROM_LAT cycles after its address
//   weights      packed kernel, tap i at [i*DATA_WIDTH +: DATA_WIDTH]
//   weights_vld  weights valid, held until accepted
//   weights_rdy  downstream accept (vld & rdy at a clock edge)
// ---------------------------------------------------------------------------
module conv_weight_fetch #(
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 16,
  parameter int KSIZE       = 3,
  parameter int NUM_KERNELS = 64,
  parameter int ROM_LAT     = 1,
  parameter int KIDX_WIDTH  = 6
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic [KIDX_WIDTH-1:0]               kernel_idx,
  output logic                                busy,
  output logic                                err,
  output logic [ADDR_WIDTH-1:0]               rom_addr,
  output logic                                rom_clk_en,
  input  logic [DATA_WIDTH-1:0]               rom_rd_data,
  output logic [KSIZE*KSIZE*DATA_WIDTH-1:0]   weights,
  output logic                                weights_vld,
  input  logic                                weights_rdy
);

  localparam int TAPS   = KSIZE * KSIZE;
  localparam int TAP_W  = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int PROD_W = KIDX_WIDTH + ADDR_WIDTH;
  localparam int KX_W   = KIDX_WIDTH + 1;
  localparam logic [TAP_W-1:0] LAST_TAP  = TAP_W'(TAPS - 1);
  localparam logic [KX_W-1:0]  NUM_K_EXT = KX_W'(NUM_KERNELS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t                 state_r;
  logic [TAP_W-1:0]       tap_r;
  logic [ROM_LAT-1:0]     pipe_vld_r;
  logic [TAP_W-1:0]       pipe_tap_r [ROM_LAT];

  logic                   in_range_s;
  logic [ADDR_WIDTH-1:0]  base_addr_s;
  logic                   cap_vld_s;
  logic [TAP_W-1:0]       cap_tap_s;
  logic                   cap_last_s;

  // Request decode and capture-stage taps of the latency delay line.
  always_comb begin
    in_range_s  = ({1'b0, kernel_idx} < NUM_K_EXT);
    // Full-width product, truncated to the address width.
    base_addr_s = ADDR_WIDTH'(PROD_W'(kernel_idx) * PROD_W'(TAPS));
    cap_vld_s   = pipe_vld_r[ROM_LAT-1];
    cap_tap_s   = pipe_tap_r[ROM_LAT-1];
    cap_last_s  = cap_vld_s && (cap_tap_s == LAST_TAP);
  end

  // Sequencer FSM; all handshake and ROM control outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      tap_r       <= '0;
      rom_addr    <= '0;
      rom_clk_en  <= 1'b0;
      busy        <= 1'b0;
      err         <= 1'b0;
      weights_vld <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (start) begin
            if (in_range_s) begin
              state_r    <= S_FETCH;
              rom_addr   <= base_addr_s;
              tap_r      <= '0;
              busy       <= 1'b1;
              rom_clk_en <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end
        end
        S_FETCH: begin
          // The last address is held rather than bumped past the kernel.
          if (tap_r == LAST_TAP) begin
            state_r <= S_DRAIN;
          end else begin
            rom_addr <= rom_addr + ADDR_WIDTH'(1);
            tap_r    <= tap_r + TAP_W'(1);
          end
        end
        S_DRAIN: begin
          if (cap_last_s) begin
            state_r     <= S_HOLD;
            rom_clk_en  <= 1'b0;
            weights_vld <= 1'b1;
          end
        end
        S_HOLD: begin
          if (weights_rdy) begin
            weights_vld <= 1'b0;
            // A start coinciding with the handshake chains straight into
            // the next fetch with no idle bubble.
            if (start && in_range_s) begin
              state_r    <= S_FETCH;
              rom_addr   <= base_addr_s;
              tap_r      <= '0;
              rom_clk_en <= 1'b1;
            end else begin
              state_r <= S_IDLE;
              busy    <= 1'b0;
              err     <= start;
            end
          end
        end
        default: begin
          state_r     <= S_IDLE;
          rom_clk_en  <= 1'b0;
          busy        <= 1'b0;
          weights_vld <= 1'b0;
        end
      endcase
    end
  end

  // Delay line tagging each issued address with its tap index, ROM_LAT deep,
  // so the returning word lands in the right slice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld_r <= '0;
      for (int k = 0; k < ROM_LAT; k++) begin
        pipe_tap_r[k] <= '0;
      end
    end else begin
      pipe_vld_r[0] <= (state_r == S_FETCH);
      pipe_tap_r[0] <= tap_r;
      for (int k = 1; k < ROM_LAT; k++) begin
        pipe_vld_r[k] <= pipe_vld_r[k-1];
        pipe_tap_r[k] <= pipe_tap_r[k-1];
      end
    end
  end

  // Weight packing; slices keep their old value until rewritten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      weights <= '0;
    end else if (cap_vld_s) begin
      for (int i = 0; i < TAPS; i++) begin
        if (cap_tap_s == TAP_W'(i)) begin
          weights[i*DATA_WIDTH +: DATA_WIDTH] <= rom_rd_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_weight_fetch.sv
// Bench for conv_weight_fetch: a ROM_LAT=1 and a ROM_LAT=2 instance share
// stimulus; a transaction-level model predicts every output each cycle.
module tb_conv_weight_fetch;

  localparam int AW   = 10;
  localparam int DW   = 16;
  localparam int K    = 3;
  localparam int TAPS = K * K;
  localparam int NK   = 64;
  localparam int KW   = 7;
  localparam int VW   = TAPS * DW;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic [KW-1:0] kernel_idx;
  logic weights_rdy;

  logic [1:0]    busy_v, err_v, clk_en_v, vld_v;
  logic [AW-1:0] addr_v [2];
  logic [DW-1:0] rd_v [2];
  logic [VW-1:0] wts_v [2];

  logic [DW-1:0] mem [1024];
  logic [DW-1:0] q1, qa, qb;

  int total = 0;
  int bad = 0;

  // model state per instance (index 0: latency 1, index 1: latency 2)
  bit m_on [2]  = '{0, 0};
  bit m_vld [2] = '{0, 0};
  bit m_err [2] = '{0, 0};
  int m_off [2] = '{0, 0};
  int m_base [2] = '{0, 0};
  int m_addr [2] = '{0, 0};
  int m_w [2][TAPS];

  always #5 clk = ~clk;

  conv_weight_fetch #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .KSIZE(K),
    .NUM_KERNELS(NK), .ROM_LAT(1), .KIDX_WIDTH(KW)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .kernel_idx(kernel_idx),
    .busy(busy_v[0]), .err(err_v[0]), .rom_addr(addr_v[0]),
    .rom_clk_en(clk_en_v[0]), .rom_rd_data(rd_v[0]), .weights(wts_v[0]),
    .weights_vld(vld_v[0]), .weights_rdy(weights_rdy));

  conv_weight_fetch #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .KSIZE(K),
    .NUM_KERNELS(NK), .ROM_LAT(2), .KIDX_WIDTH(KW)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .kernel_idx(kernel_idx),
    .busy(busy_v[1]), .err(err_v[1]), .rom_addr(addr_v[1]),
    .rom_clk_en(clk_en_v[1]), .rom_rd_data(rd_v[1]), .weights(wts_v[1]),
    .weights_vld(vld_v[1]), .weights_rdy(weights_rdy));

  initial begin
    for (int a = 0; a < 1024; a++) mem[a] = DW'(a);
  end

  // ROM models: one-stage and two-stage synchronous read
  always @(posedge clk) if (clk_en_v[0]) q1 <= mem[addr_v[0]];
  always @(posedge clk) if (clk_en_v[1]) begin qa <= mem[addr_v[1]]; qb <= qa; end
  assign rd_v[0] = q1;
  assign rd_v[1] = qb;

  task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // model: a fetch accepted at an edge is at offset 1 in the next cycle;
  // addresses on offsets 1..TAPS, tap i visible at offset i+2+lat,
  // vld from offset TAPS+lat+1 until a handshake.
  task automatic take_start(input int j);
    if (start) begin
      if (int'(kernel_idx) < NK) begin
        m_on[j] = 1; m_off[j] = 1;
        m_base[j] = int'(kernel_idx) * TAPS;
        m_addr[j] = m_base[j];
      end else begin
        m_err[j] = 1;
      end
    end
  endtask

  task automatic model_step(input int j);
    int lat;
    lat = j + 1;
    m_err[j] = 0;
    if (m_on[j]) begin
      m_off[j]++;
      if (m_off[j] <= TAPS) m_addr[j] = m_base[j] + m_off[j] - 1;
      for (int i = 0; i < TAPS; i++)
        if (m_off[j] == i + 2 + lat) m_w[j][i] = int'(mem[m_base[j] + i]);
      if (m_off[j] > TAPS + lat) begin m_on[j] = 0; m_vld[j] = 1; end
    end else if (m_vld[j]) begin
      if (weights_rdy) begin m_vld[j] = 0; take_start(j); end
    end else begin
      take_start(j);
    end
  endtask

  initial begin
    for (int j = 0; j < 2; j++) for (int i = 0; i < TAPS; i++) m_w[j][i] = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      for (int j = 0; j < 2; j++) begin
        if (!rst_n) begin
          m_on[j] = 0; m_vld[j] = 0; m_err[j] = 0; m_off[j] = 0; m_addr[j] = 0;
          for (int i = 0; i < TAPS; i++) m_w[j][i] = 0;
        end else begin
          model_step(j);
        end
      end
    end
  end

  // per-cycle comparison against the model
  initial begin
    logic [VW-1:0] ew;
    forever begin
      @(negedge clk);
      for (int j = 0; j < 2; j++) begin
        for (int i = 0; i < TAPS; i++) ew[i*DW +: DW] = DW'(m_w[j][i]);
        chk($sformatf("busy%0d", j),  VW'(busy_v[j]),   VW'(m_on[j] | m_vld[j]));
        chk($sformatf("err%0d", j),   VW'(err_v[j]),    VW'(m_err[j]));
        chk($sformatf("addr%0d", j),  VW'(addr_v[j]),   VW'(m_addr[j]));
        chk($sformatf("clken%0d", j), VW'(clk_en_v[j]), VW'(m_on[j]));
        chk($sformatf("vld%0d", j),   VW'(vld_v[j]),    VW'(m_vld[j]));
        chk($sformatf("wts%0d", j),   wts_v[j],         ew);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_slices(input string nm, input int j, input int first);
    for (int i = 0; i < TAPS; i++)
      chk(nm, VW'(wts_v[j][i*DW +: DW]), VW'(first + i));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; kernel_idx = '0; weights_rdy = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_busy", VW'(busy_v), VW'(0));
    chk("rst_vld", VW'(vld_v), VW'(0));
    chk("rst_wts", wts_v[0], VW'(0));

    // kernel 0: addresses 0..8 on cycles 1..9, vld at 11 (lat 1) / 12 (lat 2)
    kernel_idx = KW'(0); start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c == 1) start = 1'b0;
      if (c <= 9) chk("t1_addr", VW'(addr_v[0]), VW'(c - 1));
      chk("t1_vld_l1", VW'(vld_v[0]), VW'(c >= 11));
      chk("t1_vld_l2", VW'(vld_v[1]), VW'(c >= 12));
    end
    chk_slices("t1_wts_l1", 0, 0);
    chk_slices("t1_wts_l2", 0, 0);
    weights_rdy = 1'b1; tick(); weights_rdy = 1'b0;
    chk("t1_vld_drop", VW'(vld_v), VW'(0));

    // kernel 63 held under backpressure
    kernel_idx = KW'(63); start = 1'b1;
    for (int c = 1; c <= 32; c++) begin
      tick();
      if (c == 1) start = 1'b0;
      if (c >= 12) chk("t2_vld_held", VW'(vld_v), VW'(2'b11));
    end
    chk_slices("t2_wts", 0, 567);
    weights_rdy = 1'b1; tick(); weights_rdy = 1'b0;
    chk("t2_vld_drop", VW'(vld_v), VW'(0));
    chk("t2_busy_drop", VW'(busy_v), VW'(0));

    // out-of-range request
    kernel_idx = KW'(64); start = 1'b1;
    tick(); start = 1'b0;
    chk("t3_err", VW'(err_v), VW'(2'b11));
    chk("t3_busy", VW'(busy_v), VW'(0));
    chk("t3_clken", VW'(clk_en_v), VW'(0));
    chk("t3_addr", VW'(addr_v[0]), VW'(575));
    tick();
    chk("t3_err_pulse", VW'(err_v), VW'(0));

    // back-to-back with rdy tied high: kernel 5 then 6, period 11
    weights_rdy = 1'b1; kernel_idx = KW'(5); start = 1'b1;
    for (int c = 1; c <= 22; c++) begin
      tick();
      if (c == 1) kernel_idx = KW'(6);
      if (c == 10 || c == 12 || c == 21) chk("t4_vld_lo", VW'(vld_v[0]), VW'(0));
      if (c == 11 || c == 22) chk("t4_vld_hi", VW'(vld_v[0]), VW'(1));
      if (c == 12) begin
        chk("t4_nobubble", VW'(busy_v[0]), VW'(1));
        chk("t4_addr2", VW'(addr_v[0]), VW'(54));
      end
    end
    chk_slices("t4_wts", 0, 54);
    start = 1'b0;
    repeat (6) tick();
    weights_rdy = 1'b0;

    // reset mid-fetch
    kernel_idx = KW'(7); start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 1) start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk("t5_busy", VW'(busy_v), VW'(0));
    chk("t5_addr", VW'(addr_v[0]), VW'(0));
    chk("t5_clken", VW'(clk_en_v), VW'(0));
    chk("t5_wts", wts_v[0], VW'(0));
    tick(); tick();
    rst_n = 1'b1;
    for (int c = 0; c < 15; c++) begin
      tick();
      chk("t5_no_vld", VW'(vld_v), VW'(0));
    end
    kernel_idx = KW'(2); start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c == 1) start = 1'b0;
      chk("t5_vld_l1", VW'(vld_v[0]), VW'(c >= 11));
    end
    chk_slices("t5_wts_l1", 0, 18);
    chk_slices("t5_wts_l2", 1, 18);
    weights_rdy = 1'b1; tick(); weights_rdy = 1'b0;

    // latency-2 alignment: kernel 1 -> vld at cycle 12, weights 9..17
    kernel_idx = KW'(1); start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c == 1) start = 1'b0;
      chk("t6_vld_l2", VW'(vld_v[1]), VW'(c >= 12));
    end
    chk_slices("t6_wts_l2", 1, 9);
    weights_rdy = 1'b1; tick(); weights_rdy = 1'b0;

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      start = ($urandom_range(0, 2) == 0);
      kernel_idx = KW'($urandom_range(0, 70));
      weights_rdy = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 399) == 0) rst_n = 1'b0;
      else rst_n = 1'b1;
      tick();
    end
    rst_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
